// File: rtl/add_serial_sched.sv
// add_serial_sched: round-robin scheduler that shares one add_serial datapath among N_REQ
// requesters. It latches the winning requester's operands, pulses add_en to start the adder,
// counts the fixed adder latency, captures the sum, and then pulses add_en again. That second
// pulse returns the adder from DONE to IDLE, because the adder has no done flag.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   req[N_REQ]          level request per requester, sampled only while idle
//   op_a/op_b           packed operands, slice i belongs to requester i
//   ack[N_REQ]          one-cycle pulse: requester i's operands were latched
//   rsp_valid           one-cycle pulse qualifying rsp_id/rsp_data
//   rsp_id, rsp_data    requester index and sum mod 2^WIDTH of the completed add
//   busy                high whenever an operation is in flight
//   add_en, add_a/add_b to the shared adder; add_out from it
module add_serial_sched #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADD_CYCLES = 8,
  parameter int unsigned ID_W       = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  output logic [N_REQ-1:0]       ack,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy,
  output logic                   add_en,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  input  logic [WIDTH-1:0]       add_out
);

  localparam int unsigned CntW = $clog2(ADD_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ADD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StCapt} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  add_a_q, add_a_d;
  logic [WIDTH-1:0]  add_b_q, add_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;

  // Rotating priority search: the first asserted request at or after ptr_q wins.
  logic             found;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  scan_idx;

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = ID_W'((32'(ptr_q) + k) % N_REQ);
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          add_a_d = op_a[32'(winner)*WIDTH +: WIDTH];
          add_b_d = op_b[32'(winner)*WIDTH +: WIDTH];
          gid_d   = winner;
          ptr_d   = ID_W'((32'(winner) + 1) % N_REQ);
          state_d = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StCapt;
        end
      end
      StCapt: begin
        // The adder sits in DONE for exactly this cycle.
        rsp_data_d  = add_out;
        rsp_id_d    = gid_q;
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gid_q       <= '0;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Outputs decoded from the registered state are glitch-free and clear as soon as reset asserts.
  always_comb begin
    ack = '0;
    if (state_q == StStart) begin
      ack[gid_q] = 1'b1;
    end
  end

  // add_en loads the adder in StStart and releases it from DONE in StCapt.
  assign add_en    = (state_q == StStart) || (state_q == StCapt);
  assign busy      = (state_q != StIdle);
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_add_serial_sched.sv
`timescale 1ns/1ps
module tb_add_serial_sched;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int AC  = 8;
  localparam int IDW = 2;
  localparam int OPC = AC + 3;   // cycles from request sample to response
  localparam int NC  = 300;      // random-phase stimulus cycles

  localparam int           SID [4] = '{0, 2, 2, 2};
  localparam logic [W-1:0] SA  [4] = '{8'h12, 8'hFF, 8'h80, 8'h7F};
  localparam logic [W-1:0] SB  [4] = '{8'h34, 8'h01, 8'h80, 8'h01};
  localparam logic [W-1:0] SS  [4] = '{8'h46, 8'h00, 8'h00, 8'h80};

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a, op_b;
  logic [N-1:0]   ack;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic           add_en;
  logic [W-1:0]   add_a, add_b, add_out;

  int n_tests = 0;
  int n_fail  = 0;

  add_serial_sched #(
    .N_REQ(N), .WIDTH(W), .ADD_CYCLES(AC), .ID_W(IDW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
    .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_out(add_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural add_serial: IDLE -(en)-> ADD for AC cycles -> DONE -(en)-> IDLE.
  // Outside DONE the output is deliberately wrong so early/late capture is visible.
  logic [1:0]   ad_st;
  int           ad_cnt;
  logic [W-1:0] ad_sum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ad_st  <= 2'd0;
      ad_cnt <= 0;
      ad_sum <= '0;
    end else begin
      case (ad_st)
        2'd0: if (add_en) begin
          ad_sum <= add_a + add_b;
          ad_cnt <= 0;
          ad_st  <= 2'd1;
        end
        2'd1: if (ad_cnt == AC - 1) ad_st <= 2'd2; else ad_cnt <= ad_cnt + 1;
        2'd2: if (add_en) ad_st <= 2'd0;
        default: ad_st <= 2'd0;
      endcase
    end
  end
  assign add_out = (ad_st == 2'd2) ? ad_sum : ~ad_sum;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task test_reset;
    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    tick;
    tick;
    n_tests++; if (ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %b want 0", rsp_valid); end
    n_tests++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", rsp_id); end
    n_tests++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", rsp_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (add_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", add_en); end
    n_tests++; if (add_a !== 8'h00) begin n_fail++; $display("FAIL reset_add_a got %h want 00", add_a); end
    n_tests++; if (add_b !== 8'h00) begin n_fail++; $display("FAIL reset_add_b got %h want 00", add_b); end
    rst_n = 1'b1;
    tick;
    n_tests++;
    if (busy !== 1'b0 || ack !== 4'b0) begin
      n_fail++; $display("FAIL idle_noreq got busy=%b ack=%b want busy=0 ack=0000", busy, ack);
    end
  endtask

  // Single isolated requests, including the carry-discard cases.
  task test_single_ops;
    logic [N-1:0] exp_ack;
    logic         exp_en, exp_busy, exp_rv;
    for (int t = 0; t < 4; t++) begin
      req = '0;
      req[SID[t]] = 1'b1;
      op_a[SID[t]*W +: W] = SA[t];
      op_b[SID[t]*W +: W] = SB[t];
      for (int c = 1; c <= 12; c++) begin
        tick;
        exp_ack = '0;
        if (c == 1) exp_ack[SID[t]] = 1'b1;
        exp_en   = (c == 1) || (c == 10);
        exp_busy = (c <= 10);
        exp_rv   = (c == 11);
        n_tests++;
        if (ack !== exp_ack || add_en !== exp_en || busy !== exp_busy || rsp_valid !== exp_rv) begin
          n_fail++;
          $display("FAIL single_ctl op%0d c%0d got ack=%b en=%b busy=%b rv=%b want ack=%b en=%b busy=%b rv=%b",
                   t, c, ack, add_en, busy, rsp_valid, exp_ack, exp_en, exp_busy, exp_rv);
        end
        if (c == 1) begin
          n_tests++;
          if (add_a !== SA[t] || add_b !== SB[t]) begin
            n_fail++; $display("FAIL single_opnd op%0d got %h,%h want %h,%h", t, add_a, add_b, SA[t], SB[t]);
          end
          req  = '0;
          op_a = $urandom;
          op_b = $urandom;
        end
        if (c == 11) begin
          n_tests++;
          if (rsp_id !== IDW'(SID[t]) || rsp_data !== SS[t]) begin
            n_fail++;
            $display("FAIL single_rsp op%0d got id=%0d data=%h want id=%0d data=%h",
                     t, rsp_id, rsp_data, SID[t], SS[t]);
          end
        end
      end
    end
  endtask

  // All four requesters held high from reset: grants 0,1,2,3,0 spaced OPC cycles apart.
  task test_all_four;
    logic [W-1:0] sums [5];
    logic [N-1:0] exp_ack;
    logic         exp_rv, exp_busy, exp_en;
    int           g, r;
    rst_n = 1'b0;
    req   = '1;
    op_a  = $urandom;
    op_b  = $urandom;
    tick;
    tick;
    rst_n = 1'b1;
    for (int c = 1; c <= 57; c++) begin
      tick;
      exp_ack = '0;
      if (c % OPC == 1 && c <= 45) exp_ack[((c - 1) / OPC) % N] = 1'b1;
      exp_rv   = (c % OPC == 0) && (c <= 55);
      exp_busy = (c % OPC != 0) && (c < 55);
      exp_en   = ((c % OPC == 1) || (c % OPC == 10)) && (c < 55);
      n_tests++;
      if (ack !== exp_ack || rsp_valid !== exp_rv || busy !== exp_busy || add_en !== exp_en) begin
        n_fail++;
        $display("FAIL rr4_ctl c%0d got ack=%b rv=%b busy=%b en=%b want ack=%b rv=%b busy=%b en=%b",
                 c, ack, rsp_valid, busy, add_en, exp_ack, exp_rv, exp_busy, exp_en);
      end
      if (exp_rv) begin
        g = c / OPC - 1;
        n_tests++;
        if (rsp_id !== IDW'(g % N) || rsp_data !== sums[g]) begin
          n_fail++;
          $display("FAIL rr4_rsp g%0d got id=%0d data=%h want id=%0d data=%h",
                   g, rsp_id, rsp_data, g % N, sums[g]);
        end
      end
      if (c % OPC == 1 && c <= 45) begin
        g = (c - 1) / OPC;
        r = g % N;
        sums[g] = op_a[r*W +: W] + op_b[r*W +: W];
        n_tests++;
        if (add_a !== op_a[r*W +: W] || add_b !== op_b[r*W +: W]) begin
          n_fail++;
          $display("FAIL rr4_opnd g%0d got %h,%h want %h,%h", g, add_a, add_b,
                   op_a[r*W +: W], op_b[r*W +: W]);
        end
        op_a[r*W +: W] = W'($urandom);
        op_b[r*W +: W] = W'($urandom);
        if (c == 45) req = '0;
      end
    end
  endtask

  // Pointer left at 1 by the previous test: one op on req[1] moves it to 2, then
  // req[3]|req[1] must grant 3 then 1, leaving the pointer at 2 again.
  task test_pair;
    logic [N-1:0] exp_ack;
    logic [W-1:0] s1, s2, s3;
    int           exp_id;
    logic [W-1:0] exp_data;
    req = 4'b0010;
    op_a = $urandom;
    op_b = $urandom;
    for (int c = 1; c <= 12; c++) begin
      tick;
      if (c == 1) req = '0;
    end
    req = 4'b1010;
    op_a = $urandom;
    op_b = $urandom;
    s1 = op_a[1*W +: W] + op_b[1*W +: W];
    s3 = op_a[3*W +: W] + op_b[3*W +: W];
    s2 = '0;
    for (int c = 1; c <= 34; c++) begin
      tick;
      exp_ack = '0;
      if (c == 1)  exp_ack = 4'b1000;
      if (c == 12) exp_ack = 4'b0010;
      if (c == 23) exp_ack = 4'b0100;
      n_tests++;
      if (ack !== exp_ack) begin
        n_fail++; $display("FAIL pair_ack c%0d got %b want %b", c, ack, exp_ack);
      end
      n_tests++;
      if (rsp_valid !== (c == 11 || c == 22 || c == 33)) begin
        n_fail++; $display("FAIL pair_rv c%0d got %b want %b", c, rsp_valid, (c == 11 || c == 22 || c == 33));
      end
      if (c == 11 || c == 22 || c == 33) begin
        exp_id   = (c == 11) ? 3 : (c == 22) ? 1 : 2;
        exp_data = (c == 11) ? s3 : (c == 22) ? s1 : s2;
        n_tests++;
        if (rsp_id !== IDW'(exp_id) || rsp_data !== exp_data) begin
          n_fail++;
          $display("FAIL pair_rsp c%0d got id=%0d data=%h want id=%0d data=%h",
                   c, rsp_id, rsp_data, exp_id, exp_data);
        end
      end
      if (c == 1)  req[3] = 1'b0;
      if (c == 12) req[1] = 1'b0;
      if (c == 22) begin
        req = 4'b0110;
        op_a[2*W +: W] = W'($urandom);
        op_b[2*W +: W] = W'($urandom);
        s2 = op_a[2*W +: W] + op_b[2*W +: W];
      end
      if (c == 23) req = '0;
    end
  endtask

  // Reset while the adder is mid-add: everything clears, no stale response follows.
  task test_reset_mid;
    logic [W-1:0] s;
    req = 4'b0010;
    op_a = $urandom;
    op_b = $urandom;
    for (int c = 1; c <= 6; c++) begin
      tick;
      if (c == 1) begin
        n_tests++;
        if (ack !== 4'b0010) begin n_fail++; $display("FAIL midrst_ack got %b want 0010", ack); end
        req = '0;
      end
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ack, rsp_valid, rsp_id, rsp_data, busy, add_en, add_a, add_b} !== '0) begin
      n_fail++;
      $display("FAIL midrst_out got ack=%b rv=%b id=%0d data=%h busy=%b en=%b a=%h b=%h want all 0",
               ack, rsp_valid, rsp_id, rsp_data, busy, add_en, add_a, add_b);
    end
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick;
      n_tests++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL midrst_quiet c%0d got rv=%b busy=%b want 0 0", c, rsp_valid, busy);
      end
    end
    req = 4'b0010;
    op_a = $urandom;
    op_b = $urandom;
    s = op_a[1*W +: W] + op_b[1*W +: W];
    for (int c = 1; c <= 12; c++) begin
      tick;
      n_tests++;
      if (ack !== ((c == 1) ? 4'b0010 : 4'b0000) || rsp_valid !== (c == 11)) begin
        n_fail++; $display("FAIL midrst_new c%0d got ack=%b rv=%b", c, ack, rsp_valid);
      end
      if (c == 1) req = '0;
      if (c == 11) begin
        n_tests++;
        if (rsp_id !== 2'd1 || rsp_data !== s) begin
          n_fail++; $display("FAIL midrst_rsp got id=%0d data=%h want id=1 data=%h", rsp_id, rsp_data, s);
        end
      end
    end
  endtask

  // Random requesters against a transaction-level model: when free and any request is
  // pending, grant the first pending index at/after the pointer; ack follows one cycle later,
  // the response OPC cycles later, and the scheduler is free again in the response cycle.
  task test_random;
    logic [N-1:0] exp_ack  [NC+16];
    logic         exp_rv   [NC+16];
    logic         exp_busy [NC+16];
    logic         exp_en   [NC+16];
    int           exp_id   [NC+16];
    logic [W-1:0] exp_data [NC+16];
    logic         pending  [N];
    logic [W-1:0] pa [N];
    logic [W-1:0] pb [N];
    int           m_free, m_ptr, w;
    for (int i = 0; i < NC + 16; i++) begin
      exp_ack[i] = '0; exp_rv[i] = 1'b0; exp_busy[i] = 1'b0; exp_en[i] = 1'b0;
      exp_id[i] = 0; exp_data[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      pending[i] = 1'b0; pa[i] = '0; pb[i] = '0;
    end
    rst_n = 1'b0;
    req = '0;
    tick;
    tick;
    rst_n = 1'b1;
    m_free = 0;
    m_ptr  = 0;
    for (int c = 0; c < NC + 15; c++) begin
      if (c > 0) begin
        tick;
        n_tests++;
        if (ack !== exp_ack[c] || rsp_valid !== exp_rv[c] || busy !== exp_busy[c] ||
            add_en !== exp_en[c]) begin
          n_fail++;
          $display("FAIL rand_ctl c%0d got ack=%b rv=%b busy=%b en=%b want ack=%b rv=%b busy=%b en=%b",
                   c, ack, rsp_valid, busy, add_en, exp_ack[c], exp_rv[c], exp_busy[c], exp_en[c]);
        end
        if (exp_rv[c]) begin
          n_tests++;
          if (rsp_id !== IDW'(exp_id[c]) || rsp_data !== exp_data[c]) begin
            n_fail++;
            $display("FAIL rand_rsp c%0d got id=%0d data=%h want id=%0d data=%h",
                     c, rsp_id, rsp_data, exp_id[c], exp_data[c]);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (c < NC && !pending[i] && $urandom_range(0, 99) < 15) begin
          pending[i] = 1'b1;
          pa[i] = W'($urandom);
          pb[i] = W'($urandom);
        end
        req[i] = pending[i];
        op_a[i*W +: W] = pending[i] ? pa[i] : W'($urandom);
        op_b[i*W +: W] = pending[i] ? pb[i] : W'($urandom);
      end
      if (c >= m_free) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && pending[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        if (w >= 0) begin
          exp_ack[c+1][w]   = 1'b1;
          exp_en[c+1]       = 1'b1;
          exp_en[c+OPC-1]   = 1'b1;
          exp_rv[c+OPC]     = 1'b1;
          exp_id[c+OPC]     = w;
          exp_data[c+OPC]   = pa[w] + pb[w];
          for (int j = c + 1; j < c + OPC; j++) exp_busy[j] = 1'b1;
          m_ptr      = (w + 1) % N;
          m_free     = c + OPC;
          pending[w] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    test_reset;
    test_single_ops;
    test_all_four;
    test_pair;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
